// File: rtl/frame_sequencer_pkg.sv
// frame_sequencer_pkg: shared defaults and FSM state encoding for the audio front end
// Used by frame_sequencer and frame_buffer_ram; the state encoding matches hamming_window and the MFCC chain.
package frame_sequencer_pkg;
    localparam int DEF_FRAME_SIZE   = 256;
    localparam int DEF_HOP_SIZE     = 128;
    localparam int DEF_SAMPLE_WIDTH = 16;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } seq_state_t;
endpackage

// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: simple dual-port sync RAM, one write port, one registered read port
// Ports: clk; we/waddr/wdata write side; re/raddr read side; rd_data valid one cycle after re.
module frame_buffer_ram
    import frame_sequencer_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = DEF_SAMPLE_WIDTH
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [2**AW];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rd_data <= mem[raddr];
    end
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: cuts an audio stream into overlapping frames and streams them to hamming_window
// Ports: clk, rst (sync, active-high); audio_sample/sample_valid input stream (no backpressure);
//        win_sample/win_valid/win_ready/win_idx/win_frame_start/win_frame_end output stream;
//        busy, overflow (sticky dropped-sample flag), frame_count (frames fully emitted).
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_SIZE   = DEF_FRAME_SIZE,
    parameter int HOP_SIZE     = DEF_HOP_SIZE,
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SAMPLE_WIDTH-1:0]       audio_sample,
    input  logic                          sample_valid,
    output logic [SAMPLE_WIDTH-1:0]       win_sample,
    output logic                          win_valid,
    input  logic                          win_ready,
    output logic [$clog2(FRAME_SIZE)-1:0] win_idx,
    output logic                          win_frame_start,
    output logic                          win_frame_end,
    output logic                          busy,
    output logic                          overflow,
    output logic [15:0]                   frame_count
);
    localparam int DEPTH = 2 * FRAME_SIZE;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(FRAME_SIZE);
    seq_state_t state;
    logic [AW:0] wr_ptr, base_ptr, avail;
    logic [IW-1:0] rd_cnt, fl_idx;
    logic in_flight;
    logic [SAMPLE_WIDTH-1:0] rd_data;
    logic [SAMPLE_WIDTH-1:0] fifo_smp [2];
    logic [IW-1:0] fifo_idx [2];
    logic fifo_hd, fifo_tl;
    logic [1:0] fifo_cnt;
    logic [2:0] occ;
    logic full, wr_en, rd_en, pop, last_rd;
    logic [AW-1:0] rd_addr;
    // Extra wrap bit on both pointers lets avail span 0..DEPTH without ambiguity.
    assign avail   = wr_ptr - base_ptr;
    assign full    = avail == (AW+1)'(DEPTH);
    assign wr_en   = sample_valid && !full;
    assign pop     = win_valid && win_ready;
    // Occupancy counts a same-cycle pop so a freed slot is refilled at once, giving one sample per cycle.
    assign occ     = 3'(fifo_cnt) + 3'(in_flight) - 3'(pop);
    assign rd_en   = state == ST_EMIT && occ < 3'd2;
    assign rd_addr = base_ptr[AW-1:0] + AW'(rd_cnt);
    assign last_rd = rd_cnt == IW'(FRAME_SIZE - 1);
    assign win_valid       = fifo_cnt != 2'd0;
    assign win_sample      = fifo_smp[fifo_hd];
    assign win_idx         = fifo_idx[fifo_hd];
    assign win_frame_start = win_valid && win_idx == '0;
    assign win_frame_end   = win_valid && win_idx == IW'(FRAME_SIZE - 1);
    assign busy            = state == ST_EMIT || in_flight || win_valid;
    frame_buffer_ram #(.AW(AW), .DW(SAMPLE_WIDTH)) u_ram (
        .clk     (clk),
        .we      (wr_en),
        .waddr   (wr_ptr[AW-1:0]),
        .wdata   (audio_sample),
        .re      (rd_en),
        .raddr   (rd_addr),
        .rd_data (rd_data)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            base_ptr    <= '0;
            rd_cnt      <= '0;
            fl_idx      <= '0;
            in_flight   <= 1'b0;
            fifo_smp[0] <= '0;
            fifo_smp[1] <= '0;
            fifo_idx[0] <= '0;
            fifo_idx[1] <= '0;
            fifo_hd     <= 1'b0;
            fifo_tl     <= 1'b0;
            fifo_cnt    <= '0;
            overflow    <= 1'b0;
            frame_count <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (sample_valid && full) overflow <= 1'b1;
            in_flight <= rd_en;
            if (rd_en) fl_idx <= rd_cnt;
            if (state == ST_IDLE) begin
                if (avail >= (AW+1)'(FRAME_SIZE)) begin
                    state  <= ST_EMIT;
                    rd_cnt <= '0;
                end
            end else if (rd_en) begin
                if (last_rd) begin
                    base_ptr <= base_ptr + (AW+1)'(HOP_SIZE);
                    state    <= ST_IDLE;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end
            // RAM data from last cycle's read lands at the FIFO tail with its frame index.
            if (in_flight) begin
                fifo_smp[fifo_tl] <= rd_data;
                fifo_idx[fifo_tl] <= fl_idx;
                fifo_tl           <= ~fifo_tl;
            end
            if (pop) fifo_hd <= ~fifo_hd;
            fifo_cnt <= fifo_cnt + 2'(in_flight) - 2'(pop);
            if (pop && win_frame_end) frame_count <= frame_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: scoreboard bench for frame_sequencer (FS=8, HOP=4 and HOP=8 instances)
module tb_frame_sequencer;
    localparam int FS = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    logic [15:0] a_smp = '0, b_smp = '0;
    logic a_sv = 1'b0, b_sv = 1'b0;
    logic fix_rdy = 1'b1, rand_mode = 1'b0, rnd_rdy = 1'b1;
    logic a_rdy, b_rdy;
    assign a_rdy = rand_mode ? rnd_rdy : fix_rdy;
    assign b_rdy = 1'b1;
    logic [15:0] a_ws, b_ws, a_fc, b_fc;
    logic [2:0] a_wi, b_wi;
    logic a_wv, a_fs, a_fe, a_busy, a_ovf;
    logic b_wv, b_fs, b_fe, b_busy, b_ovf;
    frame_sequencer #(.FRAME_SIZE(FS), .HOP_SIZE(4), .SAMPLE_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst), .audio_sample(a_smp), .sample_valid(a_sv),
        .win_sample(a_ws), .win_valid(a_wv), .win_ready(a_rdy), .win_idx(a_wi),
        .win_frame_start(a_fs), .win_frame_end(a_fe), .busy(a_busy),
        .overflow(a_ovf), .frame_count(a_fc)
    );
    frame_sequencer #(.FRAME_SIZE(FS), .HOP_SIZE(8), .SAMPLE_WIDTH(16)) dut_b (
        .clk(clk), .rst(rst), .audio_sample(b_smp), .sample_valid(b_sv),
        .win_sample(b_ws), .win_valid(b_wv), .win_ready(b_rdy), .win_idx(b_wi),
        .win_frame_start(b_fs), .win_frame_end(b_fe), .busy(b_busy),
        .overflow(b_ovf), .frame_count(b_fc)
    );
    int vectors = 0;
    int miscompares = 0;
    int qa_s[$], qa_i[$], qb_s[$], qb_i[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    always @(posedge clk) begin
        #1 rnd_rdy = 1'($urandom_range(0, 1));
    end
    logic a_held = 1'b0;
    logic [15:0] a_hs;
    logic [2:0] a_hi;
    always @(negedge clk) begin
        if (rst) a_held = 1'b0;
        else begin
            if (a_held) begin
                check("a_stall_valid", 32'(a_wv), 1);
                check("a_stall_sample", 32'(a_ws), 32'(a_hs));
                check("a_stall_idx", 32'(a_wi), 32'(a_hi));
            end
            a_held = a_wv && !a_rdy;
            a_hs = a_ws;
            a_hi = a_wi;
            if (a_wv && a_rdy) begin
                check("a_expected_output", 32'(qa_s.size() != 0), 1);
                if (qa_s.size() != 0) begin
                    automatic int s = qa_s.pop_front();
                    automatic int i = qa_i.pop_front();
                    check("a_sample", 32'(a_ws), 32'(s));
                    check("a_idx", 32'(a_wi), 32'(i));
                    check("a_start", 32'(a_fs), 32'(i == 0));
                    check("a_end", 32'(a_fe), 32'(i == FS - 1));
                end
            end
        end
    end
    always @(negedge clk) begin
        if (!rst && b_wv) begin
            check("b_expected_output", 32'(qb_s.size() != 0), 1);
            if (qb_s.size() != 0) begin
                automatic int s = qb_s.pop_front();
                automatic int i = qb_i.pop_front();
                check("b_sample", 32'(b_ws), 32'(s));
                check("b_idx", 32'(b_wi), 32'(i));
                check("b_start", 32'(b_fs), 32'(i == 0));
                check("b_end", 32'(b_fe), 32'(i == FS - 1));
            end
        end
    end
    task automatic push_frame(input bit which, input int first);
        for (int i = 0; i < FS; i++) begin
            if (which) begin qb_s.push_back(first + i); qb_i.push_back(i); end
            else begin qa_s.push_back(first + i); qa_i.push_back(i); end
        end
    endtask
    // Called and returns at posedge+1.
    task automatic send(input bit which, input int v, input int gap);
        if (which) begin b_smp = 16'(v); b_sv = 1'b1; end
        else begin a_smp = 16'(v); a_sv = 1'b1; end
        @(posedge clk);
        #1 a_sv = 1'b0;
        b_sv = 1'b0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask
    task automatic ramp(input bit which, input int first, input int n, input int gap);
        for (int k = 0; k < n; k++) send(which, first + k, gap);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        qa_s.delete(); qa_i.delete(); qb_s.delete(); qb_i.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_valid", 32'(a_wv), 0);
        check("rst_sample", 32'(a_ws), 0);
        check("rst_idx", 32'(a_wi), 0);
        check("rst_start_end", 32'({a_fs, a_fe}), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_overflow", 32'(a_ovf), 0);
        check("rst_frame_count", 32'(a_fc), 0);
    endtask
    task automatic drain();
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (qa_s.size() + qb_s.size() == 0 && !a_busy && !b_busy) break;
        end
        check("drain_pending", 32'(qa_s.size() + qb_s.size()), 0);
        check("drain_busy", 32'({a_busy, b_busy}), 0);
        @(posedge clk);
        #1;
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end
    initial begin
        bit seen;
        @(posedge clk);
        #1;
        // reset mid-stream discards the partial frame
        do_reset();
        ramp(0, 1, 5, 0);
        do_reset();
        ramp(0, 200, 7, 3);
        repeat (6) @(posedge clk);
        #1;
        check("t1_no_early_frame", 32'({a_wv, a_busy}), 0);
        push_frame(0, 200);
        send(0, 207, 3);
        drain();
        check("t1_frame_count", 32'(a_fc), 1);
        // slow ramp, ready always high
        do_reset();
        push_frame(0, 0); push_frame(0, 4); push_frame(0, 8);
        ramp(0, 0, 16, 3);
        drain();
        check("t2_frame_count", 32'(a_fc), 3);
        check("t2_overflow", 32'(a_ovf), 0);
        // slow ramp, random ready
        do_reset();
        rand_mode = 1'b1;
        push_frame(0, 0); push_frame(0, 4); push_frame(0, 8);
        ramp(0, 0, 16, 3);
        drain();
        rand_mode = 1'b0;
        check("t3_frame_count", 32'(a_fc), 3);
        check("t3_overflow", 32'(a_ovf), 0);
        // full buffer drops sample 16
        do_reset();
        fix_rdy = 1'b0;
        push_frame(0, 0); push_frame(0, 4); push_frame(0, 8);
        ramp(0, 0, 16, 0);
        check("t4_no_overflow_at_15", 32'(a_ovf), 0);
        send(0, 16, 0);
        check("t4_overflow_at_16", 32'(a_ovf), 1);
        check("t4_stalled_busy", 32'({a_busy, a_wv}), 3);
        repeat (5) @(posedge clk);
        #1 fix_rdy = 1'b1;
        drain();
        repeat (10) @(posedge clk);
        #1;
        check("t4_frame_count", 32'(a_fc), 3);
        check("t4_overflow_sticky", 32'(a_ovf), 1);
        check("t4_no_fourth_frame", 32'(a_wv), 0);
        // reset after idx 3 aborts the frame
        do_reset();
        push_frame(0, 0);
        ramp(0, 0, 8, 0);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = a_wv && a_rdy && a_wi == 3'd3;
        end
        check("t5_idx3_seen", 32'(seen), 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t5_valid_after_rst", 32'(a_wv), 0);
        qa_s.delete(); qa_i.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        push_frame(0, 100);
        ramp(0, 100, 7, 3);
        a_smp = 16'd107;
        a_sv = 1'b1;
        @(posedge clk);
        #1 a_sv = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_latency_quiet", 32'(a_wv), 0);
        end
        @(negedge clk);
        check("t5_latency_first", 32'({a_wv, a_fs}), 3);
        check("t5_first_sample", 32'(a_ws), 100);
        drain();
        check("t5_frame_count", 32'(a_fc), 1);
        // hop equal to frame size: no overlap
        do_reset();
        push_frame(1, 0); push_frame(1, 8); push_frame(1, 16);
        ramp(1, 0, 24, 3);
        drain();
        check("t6_frame_count", 32'(b_fc), 3);
        check("t6_overflow", 32'(b_ovf), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
